// File: rtl/proj_pkg.sv
// Shared sizes, nucleotide type and serializer state encoding for the k-mer path.
package proj_pkg;

    localparam int KMER_BUFFER_BITS = 2;
    localparam int KMER_BUFFER_LEN  = 31;
    localparam int SER_WORD_NUCS    = 16;

    typedef logic [KMER_BUFFER_BITS-1:0] nuc_t;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        EMIT
    } ser_state_t;

endpackage

// File: rtl/proj_nuc_len_ctr.sv
// Saturating sequence-length counter with registered kmer_valid and, when
// PROJ_SER_LEN_CHECK_EN is defined, a short-sequence seq_err pulse.
module proj_nuc_len_ctr
    import proj_pkg::*;
#(
    parameter int KMER_LEN = KMER_BUFFER_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
`ifdef PROJ_SER_LEN_CHECK_EN
    input  logic close_hs,
    input  logic close_empty,
`endif
    output logic kmer_valid,
    output logic seq_err
);

    localparam int LEN_W = $clog2(KMER_LEN + 1);

    logic [LEN_W-1:0] len_q;
    logic             kmer_valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q        <= '0;
            kmer_valid_q <= 1'b0;
        end else begin
            if (clr) begin
                len_q <= '0;
            end else if (inc && (len_q != LEN_W'(KMER_LEN))) begin
                len_q <= len_q + LEN_W'(1);
            end
            // High only right after a handshake that leaves the count at KMER_LEN.
            kmer_valid_q <= inc && (len_q >= LEN_W'(KMER_LEN - 1));
        end
    end

    assign kmer_valid = kmer_valid_q;

`ifdef PROJ_SER_LEN_CHECK_EN
    logic seq_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seq_err_q <= 1'b0;
        end else begin
            seq_err_q <= (close_hs && (len_q < LEN_W'(KMER_LEN - 1)))
                      || (close_empty && (len_q < LEN_W'(KMER_LEN)));
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: rtl/proj_nuc_serializer.sv
// Packed-word to nucleotide serializer feeding the k-mer shift buffer.
// Optional length check enabled by defining PROJ_SER_LEN_CHECK_EN.
//
//   state | meaning
//   IDLE  | waiting for a word; in_ready high
//   CLEAR | start_over pulse to the k-mer buffer before a new sequence
//   EMIT  | presenting word[idx], advancing on each out handshake
module proj_nuc_serializer
    import proj_pkg::*;
#(
    parameter int DATA_BITS = KMER_BUFFER_BITS,
    parameter int KMER_LEN  = KMER_BUFFER_LEN,
    parameter int WORD_NUCS = SER_WORD_NUCS
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WORD_NUCS-1:0][DATA_BITS-1:0]  in_word,
    input  logic                                 in_last,
    input  logic [$clog2(WORD_NUCS+1)-1:0]       in_count,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DATA_BITS-1:0]                 out_nuc,
    output logic                                 out_last,
    output logic                                 start_over,
    output logic                                 kmer_valid,
    output logic                                 seq_err
);

    localparam int CNT_W = $clog2(WORD_NUCS + 1);
    localparam int IDX_W = (WORD_NUCS > 1) ? $clog2(WORD_NUCS) : 1;

    ser_state_t                          state_q, state_d;
    logic [WORD_NUCS-1:0][DATA_BITS-1:0] word_q;
    logic                                last_q;
    logic [CNT_W-1:0]                    cnt_q;
    logic [IDX_W-1:0]                    idx_q;
    logic                                seq_open_q;

    logic hs, at_end, zero_last, load, seq_close, in_ready_c;

    assign hs        = (state_q == EMIT) && out_ready;
    assign at_end    = (CNT_W'(idx_q) == (cnt_q - CNT_W'(1)));
    assign zero_last = in_last && (in_count == '0);

    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        load       = 1'b0;
        seq_close  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    load = 1'b1;
                    if (zero_last) begin
                        seq_close = 1'b1;
                    end else if (!seq_open_q) begin
                        state_d = CLEAR;
                    end else begin
                        state_d = EMIT;
                    end
                end
            end
            CLEAR: state_d = EMIT;
            EMIT: begin
                if (hs && at_end) begin
                    if (last_q) begin
                        seq_close = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        // Word boundary: take the next word in the same cycle to avoid a bubble.
                        in_ready_c = 1'b1;
                        if (in_valid) begin
                            load = 1'b1;
                            if (zero_last) begin
                                seq_close = 1'b1;
                                state_d   = IDLE;
                            end
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_q     <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            seq_open_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                word_q <= in_word;
                last_q <= in_last;
                cnt_q  <= in_last ? in_count : CNT_W'(WORD_NUCS);
                idx_q  <= '0;
            end else if (hs && !at_end) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            if (state_q == CLEAR) begin
                seq_open_q <= 1'b1;
            end else if (seq_close) begin
                seq_open_q <= 1'b0;
            end
        end
    end

    assign in_ready   = rst_n && in_ready_c;
    assign out_valid  = (state_q == EMIT);
    assign out_nuc    = (state_q == EMIT) ? word_q[idx_q] : '0;
    assign out_last   = (state_q == EMIT) && last_q && at_end;
    assign start_over = (state_q == CLEAR);

`ifdef PROJ_SER_LEN_CHECK_EN
    logic close_hs, close_empty;
    assign close_hs    = hs && out_last;
    assign close_empty = load && zero_last && seq_open_q;
`endif

    proj_nuc_len_ctr #(
        .KMER_LEN (KMER_LEN)
    ) u_len (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (state_q == CLEAR),
        .inc         (hs),
`ifdef PROJ_SER_LEN_CHECK_EN
        .close_hs    (close_hs),
        .close_empty (close_empty),
`endif
        .kmer_valid  (kmer_valid),
        .seq_err     (seq_err)
    );

endmodule

// File: tb/tb_proj_nuc_serializer.sv
// Directed bench for proj_nuc_serializer with WORD_NUCS=4, KMER_LEN=3, DATA_BITS=2.
module tb_proj_nuc_serializer;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0][1:0] in_word;
    logic            in_last;
    logic [2:0]      in_count;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_nuc;
    logic            out_last;
    logic            start_over;
    logic            kmer_valid;
    logic            seq_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    proj_nuc_serializer #(
        .DATA_BITS (2),
        .KMER_LEN  (3),
        .WORD_NUCS (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .in_last    (in_last),
        .in_count   (in_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_nuc    (out_nuc),
        .out_last   (out_last),
        .start_over (start_over),
        .kmer_valid (kmer_valid),
        .seq_err    (seq_err)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w, input logic last, input logic [2:0] cnt);
        in_word  = w;
        in_last  = last;
        in_count = cnt;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_word = '0; in_last = 1'b0; in_count = '0; out_ready = 1'b1;
        step(); step();
        n_tests++;
        if ({in_ready, out_valid, out_nuc, out_last, start_over, kmer_valid, seq_err} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {in_ready, out_valid, out_nuc, out_last, start_over, kmer_valid, seq_err});
        end
        rst_n = 1'b1;
        step();
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if (start_over !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_quiet[%0d]: start_over=%b out_valid=%b expected 0 0", i, start_over, out_valid);
            end
        end
    endtask

    task automatic test_single_word();
        send(8'hE4, 1'b1, 3'd4);
        step();
        in_valid = 1'b0;
        n_tests++;
        if (start_over !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_clear: start_over=%b out_valid=%b expected 1 0", start_over, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_nuc !== 2'(i) || out_last !== (i == 3) || kmer_valid !== (i == 3)
                || start_over !== 1'b0) begin
                n_fail++;
                $display("FAIL single_nuc[%0d]: valid=%b nuc=%0d last=%b kmer=%b so=%b expected 1 %0d %b %b 0",
                         i, out_valid, out_nuc, out_last, kmer_valid, start_over, i, (i == 3), (i == 3));
            end
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0 || kmer_valid !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_end: valid=%b kmer=%b in_ready=%b expected 0 1 1", out_valid, kmer_valid, in_ready);
        end
        step();
        n_tests++;
        if (kmer_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_kmer_drop: got %b expected 0", kmer_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_nuc [6] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd2, 2'd3};
        logic       exp_rdy [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        send(8'h1B, 1'b0, 3'd0);
        step();
        n_tests++;
        if (start_over !== 1'b1) begin
            n_fail++; $display("FAIL b2b_clear: start_over=%b expected 1", start_over);
        end
        send(8'h0E, 1'b1, 3'd2);
        for (int i = 0; i < 6; i++) begin
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_nuc !== exp_nuc[i] || in_ready !== exp_rdy[i]
                || out_last !== (i == 5) || start_over !== 1'b0 || kmer_valid !== (i >= 3)) begin
                n_fail++;
                $display("FAIL b2b_nuc[%0d]: valid=%b nuc=%0d rdy=%b last=%b so=%b kmer=%b expected 1 %0d %b %b 0 %b",
                         i, out_valid, out_nuc, in_ready, out_last, start_over, kmer_valid,
                         exp_nuc[i], exp_rdy[i], (i == 5), (i >= 3));
            end
            if (i == 4) in_valid = 1'b0;
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0 || start_over !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end: valid=%b so=%b expected 0 0", out_valid, start_over);
        end
    endtask

    task automatic test_stall();
        send(8'hE4, 1'b1, 3'd4);
        step();
        in_valid = 1'b0;
        step(); step(); step();
        n_tests++;
        if (out_nuc !== 2'd2 || dut.idx_q !== 2'd2 || dut.u_len.len_q !== 2'd2) begin
            n_fail++;
            $display("FAIL stall_pre: nuc=%0d idx=%0d len=%0d expected 2 2 2", out_nuc, dut.idx_q, dut.u_len.len_q);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_nuc !== 2'd2 || out_last !== 1'b0 || dut.idx_q !== 2'd2
                || dut.u_len.len_q !== 2'd2 || kmer_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%b nuc=%0d last=%b idx=%0d len=%0d kmer=%b expected 1 2 0 2 2 0",
                         i, out_valid, out_nuc, out_last, dut.idx_q, dut.u_len.len_q, kmer_valid);
            end
        end
        out_ready = 1'b1;
        step();
        n_tests++;
        if (out_nuc !== 2'd3 || out_last !== 1'b1 || kmer_valid !== 1'b1) begin
            n_fail++; $display("FAIL stall_resume: nuc=%0d last=%b kmer=%b expected 3 1 1", out_nuc, out_last, kmer_valid);
        end
        step(); step();
    endtask

    task automatic test_short_seq();
        int err_pulses = 0;
        int exp_err;
        logic [1:0] exp_nuc [2] = '{2'd1, 2'd1};
`ifdef PROJ_SER_LEN_CHECK_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        send(8'h05, 1'b1, 3'd2);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_nuc !== exp_nuc[i] || out_last !== (i == 1)) begin
                n_fail++;
                $display("FAIL short_nuc[%0d]: valid=%b nuc=%0d last=%b expected 1 1 %b", i, out_valid, out_nuc, out_last, (i == 1));
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (seq_err === 1'b1) err_pulses++;
            n_tests++;
            if (kmer_valid !== 1'b0) begin
                n_fail++; $display("FAIL short_kmer[%0d]: got %b expected 0", i, kmer_valid);
            end
            step();
        end
        n_tests++;
        if (err_pulses != exp_err) begin
            n_fail++; $display("FAIL short_seq_err: pulses %0d expected %0d", err_pulses, exp_err);
        end
    endtask

    task automatic test_reset_in_emit();
        logic [1:0] exp_nuc [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
        send(8'hE4, 1'b1, 3'd4);
        step();
        in_valid = 1'b0;
        step(); step();
        rst_n = 1'b0;
        step();
        n_tests++;
        if ({in_ready, out_valid, out_nuc, out_last, start_over, kmer_valid, seq_err} !== 8'h00) begin
            n_fail++;
            $display("FAIL emit_reset_outputs: got %b expected 00000000",
                     {in_ready, out_valid, out_nuc, out_last, start_over, kmer_valid, seq_err});
        end
        rst_n = 1'b1;
        step();
        send(8'h1B, 1'b0, 3'd0);
        step();
        in_valid = 1'b0;
        n_tests++;
        if (start_over !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL emit_reset_clear: so=%b valid=%b expected 1 0", start_over, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_nuc !== exp_nuc[i] || out_last !== 1'b0) begin
                n_fail++;
                $display("FAIL emit_reset_nuc[%0d]: valid=%b nuc=%0d last=%b expected 1 %0d 0", i, out_valid, out_nuc, out_last, exp_nuc[i]);
            end
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL emit_reset_idle: valid=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_continuation();
        send(8'h0E, 1'b1, 3'd2);
        step();
        in_valid = 1'b0;
        n_tests++;
        if (start_over !== 1'b0 || out_valid !== 1'b1 || out_nuc !== 2'd2 || kmer_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_first: so=%b valid=%b nuc=%0d kmer=%b expected 0 1 2 0", start_over, out_valid, out_nuc, kmer_valid);
        end
        step();
        n_tests++;
        if (out_nuc !== 2'd3 || out_last !== 1'b1 || kmer_valid !== 1'b1) begin
            n_fail++; $display("FAIL cont_last: nuc=%0d last=%b kmer=%b expected 3 1 1", out_nuc, out_last, kmer_valid);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0 || dut.seq_open_q !== 1'b0) begin
            n_fail++; $display("FAIL cont_close: valid=%b seq_open=%b expected 0 0", out_valid, dut.seq_open_q);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_short_seq();
        test_reset_in_emit();
        test_continuation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
